// File: rtl/riscv_execute.sv
// riscv_execute: RV32 execute stage with operand forwarding, ALU, branch resolution and the EX/MEM register.
// Define RV32M_EN to build the single-cycle multiplier and the iterative divider (ALU codes 16..23).
module riscv_execute #(
    parameter int XLEN      = 32,
    parameter int DIV_CNT_W = 6
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_reg_write_e,
    input  logic [1:0]      i_result_src_e,
    input  logic            i_mem_write_e,
    input  logic            i_branch_e,
    input  logic            i_jump_e,
    input  logic            i_jalr_e,
    input  logic            i_alu_src_e,
    input  logic [4:0]      i_alu_ctrl_e,
    input  logic [2:0]      i_funct3_e,
    input  logic [3:0]      i_ctrl_mem_byte_sel_e,
    input  logic [XLEN-1:0] i_rd1_e,
    input  logic [XLEN-1:0] i_rd2_e,
    input  logic [XLEN-1:0] i_pc_e,
    input  logic [XLEN-1:0] i_pc_plus_4e,
    input  logic [XLEN-1:0] i_ext_imm_e,
    input  logic [4:0]      i_rd_e,
    input  logic [1:0]      i_fwd_a_e,
    input  logic [1:0]      i_fwd_b_e,
    input  logic [XLEN-1:0] i_result_w,
    output logic            o_pc_src_e,
    output logic [XLEN-1:0] o_pc_target_e,
    output logic            o_stall_e,
    output logic            o_reg_write_m,
    output logic [1:0]      o_result_src_m,
    output logic            o_mem_write_m,
    output logic [XLEN-1:0] o_alu_result_m,
    output logic [XLEN-1:0] o_write_data_m,
    output logic [4:0]      o_rd_m,
    output logic [XLEN-1:0] o_pc_plus_4m,
    output logic [XLEN-1:0] o_ext_imm_m,
    output logic [2:0]      o_mem_funct3,
    output logic [3:0]      o_ctrl_mem_byte_sel_m
);
    logic [XLEN-1:0] src_a, src_b, write_data, alu_res, ex_res;
    logic            cond;

    always_comb begin
        src_a      = i_fwd_a_e == 2'b01 ? i_result_w : i_fwd_a_e == 2'b10 ? o_alu_result_m : i_rd1_e;
        write_data = i_fwd_b_e == 2'b01 ? i_result_w : i_fwd_b_e == 2'b10 ? o_alu_result_m : i_rd2_e;
        src_b      = i_alu_src_e ? i_ext_imm_e : write_data;
    end

`ifdef RV32M_EN
    // Sign/zero-extend both operands to 2*XLEN so one multiplier covers all four MUL variants.
    logic              mul_sa, mul_sb;
    logic [2*XLEN-1:0] prod;
    assign mul_sa = (i_alu_ctrl_e == 5'd17 || i_alu_ctrl_e == 5'd18) && src_a[XLEN-1];
    assign mul_sb = i_alu_ctrl_e == 5'd17 && src_b[XLEN-1];
    assign prod   = {{XLEN{mul_sa}}, src_a} * {{XLEN{mul_sb}}, src_b};
`endif

    always_comb begin
        case (i_alu_ctrl_e)
            5'd0:  alu_res = src_a + src_b;
            5'd1:  alu_res = src_a - src_b;
            5'd2:  alu_res = src_a & src_b;
            5'd3:  alu_res = src_a | src_b;
            5'd4:  alu_res = src_a ^ src_b;
            5'd5:  alu_res = src_a << src_b[4:0];
            5'd6:  alu_res = src_a >> src_b[4:0];
            5'd7:  alu_res = $unsigned($signed(src_a) >>> src_b[4:0]);
            5'd8:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            5'd9:  alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            5'd10: alu_res = src_b;
`ifdef RV32M_EN
            5'd16: alu_res = prod[XLEN-1:0];
            5'd17, 5'd18, 5'd19: alu_res = prod[2*XLEN-1:XLEN];
`endif
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        case (i_funct3_e)
            3'b000:  cond = src_a == write_data;
            3'b001:  cond = src_a != write_data;
            3'b100:  cond = $signed(src_a) < $signed(write_data);
            3'b101:  cond = $signed(src_a) >= $signed(write_data);
            3'b110:  cond = src_a < write_data;
            3'b111:  cond = src_a >= write_data;
            default: cond = 1'b0;
        endcase
    end

    assign o_pc_target_e = i_jalr_e ? ((src_a + i_ext_imm_e) & ~{{(XLEN-1){1'b0}}, 1'b1}) : i_pc_e + i_ext_imm_e;
    assign o_pc_src_e    = ~o_stall_e & (i_jump_e | (i_branch_e & cond));

`ifdef RV32M_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
    div_state_t           state_q, state_d;
    logic [XLEN-1:0]      quo_q, rem_q, dvs_q, dvd_q, mag_a, mag_b, div_res;
    logic [DIV_CNT_W-1:0] cnt_q;
    logic                 neg_q_q, neg_r_q, rem_sel_q, zero_q, is_div, sgn;
    logic [XLEN:0]        r_shift, diff;

    assign is_div    = i_alu_ctrl_e[4:2] == 3'b101;
    assign sgn       = ~i_alu_ctrl_e[0];
    assign mag_a     = sgn && src_a[XLEN-1] ? -src_a : src_a;
    assign mag_b     = sgn && src_b[XLEN-1] ? -src_b : src_b;
    assign r_shift   = {rem_q, quo_q[XLEN-1]};
    assign diff      = r_shift - {1'b0, dvs_q};
    assign o_stall_e = (state_q == IDLE && is_div) || state_q == BUSY;
    assign div_res   = zero_q    ? (rem_sel_q ? dvd_q : '1) :
                       rem_sel_q ? (neg_r_q ? -rem_q : rem_q) : (neg_q_q ? -quo_q : quo_q);
    assign ex_res    = state_q == DONE ? div_res : alu_res;

    always_comb begin
        state_d = state_q;
        state_d = state_q == IDLE ? (is_div ? BUSY : IDLE) :
                  state_q == BUSY ? (cnt_q == DIV_CNT_W'(1) ? DONE : BUSY) : IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) state_q <= IDLE;
        else state_q <= state_d;
    end

    // Restoring division on magnitudes; signs are reapplied when the result is read in DONE.
    always_ff @(posedge i_clk) begin
        if (state_q == IDLE && is_div) begin
            quo_q     <= mag_a;
            rem_q     <= '0;
            dvs_q     <= mag_b;
            dvd_q     <= src_a;
            cnt_q     <= DIV_CNT_W'(XLEN);
            neg_q_q   <= sgn & (src_a[XLEN-1] ^ src_b[XLEN-1]);
            neg_r_q   <= sgn & src_a[XLEN-1];
            rem_sel_q <= i_alu_ctrl_e[1];
            zero_q    <= src_b == '0;
        end else if (state_q == BUSY) begin
            rem_q <= diff[XLEN] ? r_shift[XLEN-1:0] : diff[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], ~diff[XLEN]};
            cnt_q <= cnt_q - DIV_CNT_W'(1);
        end
    end
`else
    assign o_stall_e = 1'b0;
    assign ex_res    = alu_res;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_reg_write_m         <= 1'b0;
            o_result_src_m        <= '0;
            o_mem_write_m         <= 1'b0;
            o_alu_result_m        <= '0;
            o_write_data_m        <= '0;
            o_rd_m                <= '0;
            o_pc_plus_4m          <= '0;
            o_ext_imm_m           <= '0;
            o_mem_funct3          <= '0;
            o_ctrl_mem_byte_sel_m <= '0;
        end else begin
            o_reg_write_m <= i_reg_write_e & ~o_stall_e;
            o_mem_write_m <= i_mem_write_e & ~o_stall_e;
            if (!o_stall_e) begin
                o_result_src_m        <= i_result_src_e;
                o_alu_result_m        <= ex_res;
                o_write_data_m        <= write_data;
                o_rd_m                <= i_rd_e;
                o_pc_plus_4m          <= i_pc_plus_4e;
                o_ext_imm_m           <= i_ext_imm_e;
                o_mem_funct3          <= i_funct3_e;
                o_ctrl_mem_byte_sel_m <= i_ctrl_mem_byte_sel_e;
            end
        end
    end
endmodule

// File: tb/tb_riscv_execute.sv
// tb_riscv_execute: directed vectors for riscv_execute; expectations follow RV32M_EN.
module tb_riscv_execute;
`ifdef RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif
    logic        clk = 1'b0, rstn = 1'b0;
    logic        i_reg_write_e, i_mem_write_e, i_branch_e, i_jump_e, i_jalr_e, i_alu_src_e;
    logic [1:0]  i_result_src_e, i_fwd_a_e, i_fwd_b_e;
    logic [4:0]  i_alu_ctrl_e, i_rd_e;
    logic [2:0]  i_funct3_e;
    logic [3:0]  i_ctrl_mem_byte_sel_e;
    logic [31:0] i_rd1_e, i_rd2_e, i_pc_e, i_pc_plus_4e, i_ext_imm_e, i_result_w;
    logic        o_pc_src_e, o_stall_e, o_reg_write_m, o_mem_write_m;
    logic [31:0] o_pc_target_e, o_alu_result_m, o_write_data_m, o_pc_plus_4m, o_ext_imm_m;
    logic [1:0]  o_result_src_m;
    logic [4:0]  o_rd_m;
    logic [2:0]  o_mem_funct3;
    logic [3:0]  o_ctrl_mem_byte_sel_m;
    int nvec = 0, nerr = 0;

    typedef struct {logic [4:0] op; logic [31:0] a, b, e;} alu_vec_t;
    typedef struct {logic [2:0] f3; logic [31:0] a, b; logic t;} br_vec_t;

    riscv_execute dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_reg_write_e(i_reg_write_e), .i_result_src_e(i_result_src_e), .i_mem_write_e(i_mem_write_e),
        .i_branch_e(i_branch_e), .i_jump_e(i_jump_e), .i_jalr_e(i_jalr_e), .i_alu_src_e(i_alu_src_e),
        .i_alu_ctrl_e(i_alu_ctrl_e), .i_funct3_e(i_funct3_e), .i_ctrl_mem_byte_sel_e(i_ctrl_mem_byte_sel_e),
        .i_rd1_e(i_rd1_e), .i_rd2_e(i_rd2_e), .i_pc_e(i_pc_e), .i_pc_plus_4e(i_pc_plus_4e),
        .i_ext_imm_e(i_ext_imm_e), .i_rd_e(i_rd_e), .i_fwd_a_e(i_fwd_a_e), .i_fwd_b_e(i_fwd_b_e),
        .i_result_w(i_result_w), .o_pc_src_e(o_pc_src_e), .o_pc_target_e(o_pc_target_e),
        .o_stall_e(o_stall_e), .o_reg_write_m(o_reg_write_m), .o_result_src_m(o_result_src_m),
        .o_mem_write_m(o_mem_write_m), .o_alu_result_m(o_alu_result_m), .o_write_data_m(o_write_data_m),
        .o_rd_m(o_rd_m), .o_pc_plus_4m(o_pc_plus_4m), .o_ext_imm_m(o_ext_imm_m),
        .o_mem_funct3(o_mem_funct3), .o_ctrl_mem_byte_sel_m(o_ctrl_mem_byte_sel_m)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        {i_reg_write_e, i_mem_write_e, i_branch_e, i_jump_e, i_jalr_e, i_alu_src_e} = '0;
        {i_result_src_e, i_fwd_a_e, i_fwd_b_e, i_alu_ctrl_e, i_rd_e, i_funct3_e, i_ctrl_mem_byte_sel_e} = '0;
        {i_rd1_e, i_rd2_e, i_pc_e, i_pc_plus_4e, i_ext_imm_e, i_result_w} = '0;
    endtask

    // Runs one divide to completion and reports what was observed; callers do the comparisons.
    task automatic do_div(input logic [4:0] op, input logic [31:0] a, b,
                          output logic [31:0] res, output int cyc, output bit bubble, output logic rw);
        clear();
        i_reg_write_e = 1'b1; i_alu_ctrl_e = op; i_rd1_e = a; i_rd2_e = b; i_rd_e = 5'd7;
        #1;
        cyc = 0;
        bubble = 1'b1;
        while (o_stall_e && cyc < 100) begin
            cyc++;
            step();
            if (o_reg_write_m !== 1'b0) bubble = 1'b0;
            i_fwd_a_e = 2'b01; i_result_w = 32'hDEAD_BEEF;
            #1;
        end
        step();
        res = o_alu_result_m;
        rw  = o_reg_write_m;
    endtask

    task automatic test_reset();
        clear();
        rstn = 1'b0;
        step(); step();
        nvec++;
        if ({o_reg_write_m, o_result_src_m, o_mem_write_m, o_alu_result_m, o_write_data_m, o_rd_m,
             o_pc_plus_4m, o_ext_imm_m, o_mem_funct3, o_ctrl_mem_byte_sel_m} !== '0) begin
            nerr++; $display("FAIL reset_exmem: alu=%h rw=%b rd=%0d, all-zero required", o_alu_result_m, o_reg_write_m, o_rd_m);
        end
        nvec++;
        if (o_stall_e !== 1'b0) begin nerr++; $display("FAIL reset_stall: got %b expected 0", o_stall_e); end
        rstn = 1'b1;
    endtask

    task automatic test_add();
        clear();
        i_reg_write_e = 1'b1; i_alu_src_e = 1'b1; i_rd1_e = 32'd5; i_ext_imm_e = 32'd7; i_rd_e = 5'd3;
        step();
        nvec++;
        if (o_alu_result_m !== 32'd12) begin nerr++; $display("FAIL add_result: got %h expected 0000000c", o_alu_result_m); end
        nvec++;
        if ({o_reg_write_m, o_rd_m} !== {1'b1, 5'd3}) begin nerr++; $display("FAIL add_ctrl: rw=%b rd=%0d expected 1/3", o_reg_write_m, o_rd_m); end
    endtask

    task automatic test_forward();
        clear();
        i_rd1_e = 32'h20; step();
        clear();
        i_alu_ctrl_e = 5'd1; i_fwd_a_e = 2'b10; i_rd1_e = 32'h999; i_rd2_e = 32'd3;
        step();
        nvec++;
        if (o_alu_result_m !== 32'h1D) begin nerr++; $display("FAIL sub_fwd_mem: got %h expected 0000001d", o_alu_result_m); end
        clear();
        i_alu_ctrl_e = 5'd0; i_fwd_b_e = 2'b01; i_result_w = 32'h40; i_rd1_e = 32'h3; i_rd2_e = 32'h777;
        step();
        nvec++;
        if (o_alu_result_m !== 32'h43) begin nerr++; $display("FAIL add_fwd_wb: got %h expected 00000043", o_alu_result_m); end
    endtask

    task automatic test_alu_ops();
        alu_vec_t v[14];
        v = '{'{5'd2, 32'hF0F0, 32'hFF00, 32'hF000}, '{5'd3, 32'hF0F0, 32'h0F0F, 32'hFFFF},
              '{5'd4, 32'hFFFF, 32'h0F0F, 32'hF0F0}, '{5'd5, 32'h1, 32'd36, 32'h10},
              '{5'd6, 32'h8000_0000, 32'd4, 32'h0800_0000}, '{5'd7, 32'h8000_0000, 32'd4, 32'hF800_0000},
              '{5'd8, 32'hFFFF_FFFF, 32'd1, 32'd1}, '{5'd9, 32'hFFFF_FFFF, 32'd1, 32'd0},
              '{5'd10, 32'h1234, 32'h77, 32'h77}, '{5'd11, 32'd5, 32'd6, 32'd0},
              '{5'd16, 32'hFFFF_FFFF, 32'd2, M_EN ? 32'hFFFF_FFFE : 32'd0},
              '{5'd17, 32'hFFFF_FFFF, 32'd2, M_EN ? 32'hFFFF_FFFF : 32'd0},
              '{5'd18, 32'd2, 32'hFFFF_FFFF, M_EN ? 32'd1 : 32'd0},
              '{5'd19, 32'hFFFF_FFFF, 32'd2, M_EN ? 32'd1 : 32'd0}};
        for (int i = 0; i < 14; i++) begin
            clear();
            i_alu_ctrl_e = v[i].op; i_rd1_e = v[i].a; i_rd2_e = v[i].b;
            step();
            nvec++;
            if (o_alu_result_m !== v[i].e) begin
                nerr++; $display("FAIL alu_op%0d: got %h expected %h", v[i].op, o_alu_result_m, v[i].e);
            end
        end
    endtask

    task automatic test_passthrough();
        clear();
        i_reg_write_e = 1'b1; i_result_src_e = 2'd2; i_mem_write_e = 1'b1; i_funct3_e = 3'b010;
        i_ctrl_mem_byte_sel_e = 4'hF; i_rd2_e = 32'hCAFE; i_fwd_b_e = 2'b01; i_result_w = 32'h55;
        i_pc_plus_4e = 32'h104; i_ext_imm_e = 32'h8; i_alu_src_e = 1'b1; i_rd1_e = 32'h1000; i_rd_e = 5'd9;
        step();
        nvec++;
        if ({o_reg_write_m, o_result_src_m, o_mem_write_m, o_alu_result_m, o_write_data_m, o_rd_m,
             o_pc_plus_4m, o_ext_imm_m, o_mem_funct3, o_ctrl_mem_byte_sel_m} !==
            {1'b1, 2'd2, 1'b1, 32'h1008, 32'h55, 5'd9, 32'h104, 32'h8, 3'b010, 4'hF}) begin
            nerr++; $display("FAIL passthrough: alu=%h wd=%h pc4=%h imm=%h f3=%b bs=%h rd=%0d",
                             o_alu_result_m, o_write_data_m, o_pc_plus_4m, o_ext_imm_m, o_mem_funct3, o_ctrl_mem_byte_sel_m, o_rd_m);
        end
    endtask

    task automatic test_branch();
        br_vec_t v[6];
        v = '{'{3'b000, 32'd9, 32'd9, 1'b1}, '{3'b001, 32'd9, 32'd9, 1'b0},
              '{3'b100, 32'hFFFF_FFFF, 32'd1, 1'b1}, '{3'b110, 32'hFFFF_FFFF, 32'd1, 1'b0},
              '{3'b101, 32'd1, 32'hFFFF_FFFF, 1'b1}, '{3'b011, 32'd9, 32'd9, 1'b0}};
        for (int i = 0; i < 6; i++) begin
            clear();
            i_branch_e = 1'b1; i_funct3_e = v[i].f3; i_rd1_e = v[i].a; i_rd2_e = v[i].b;
            i_pc_e = 32'h100; i_ext_imm_e = 32'h40;
            #1;
            nvec++;
            if ({o_pc_src_e, o_pc_target_e} !== {v[i].t, 32'h140}) begin
                nerr++; $display("FAIL branch_f3_%b: src=%b tgt=%h expected %b/00000140", v[i].f3, o_pc_src_e, o_pc_target_e, v[i].t);
            end
        end
        clear();
        i_jump_e = 1'b1; i_jalr_e = 1'b1; i_rd1_e = 32'h203; i_pc_e = 32'h500;
        #1;
        nvec++;
        if ({o_pc_src_e, o_pc_target_e} !== {1'b1, 32'h202}) begin
            nerr++; $display("FAIL jalr: src=%b tgt=%h expected 1/00000202", o_pc_src_e, o_pc_target_e);
        end
        step();
    endtask

    task automatic test_div();
        logic [31:0] r; int c; bit b; logic rw;
        do_div(5'd20, 32'hFFFF_FFF9, 32'd2, r, c, b, rw);
        nvec++;
        if (c !== (M_EN ? 33 : 0)) begin nerr++; $display("FAIL div_stall_cycles: got %0d expected %0d", c, M_EN ? 33 : 0); end
        nvec++;
        if (b !== 1'b1) begin nerr++; $display("FAIL div_bubble: reg_write_m high during stall, expected 0"); end
        nvec++;
        if (r !== (M_EN ? 32'hFFFF_FFFD : 32'd0)) begin nerr++; $display("FAIL div_result: got %h expected %h", r, M_EN ? 32'hFFFF_FFFD : 32'd0); end
        nvec++;
        if (rw !== 1'b1) begin nerr++; $display("FAIL div_capture_rw: got %b expected 1", rw); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int c; bit b; logic rw;
        do_div(5'd22, 32'hFFFF_FFF9, 32'd2, r, c, b, rw);
        nvec++;
        if (r !== (M_EN ? 32'hFFFF_FFFF : 32'd0)) begin nerr++; $display("FAIL rem_result: got %h expected %h", r, M_EN ? 32'hFFFF_FFFF : 32'd0); end
        do_div(5'd21, 32'h1234, 32'd0, r, c, b, rw);
        nvec++;
        if (r !== (M_EN ? 32'hFFFF_FFFF : 32'd0)) begin nerr++; $display("FAIL divu_by_zero: got %h expected %h", r, M_EN ? 32'hFFFF_FFFF : 32'd0); end
        do_div(5'd23, 32'h1234, 32'd0, r, c, b, rw);
        nvec++;
        if (r !== (M_EN ? 32'h1234 : 32'd0)) begin nerr++; $display("FAIL remu_by_zero: got %h expected %h", r, M_EN ? 32'h1234 : 32'd0); end
        do_div(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, r, c, b, rw);
        nvec++;
        if (r !== (M_EN ? 32'h8000_0000 : 32'd0)) begin nerr++; $display("FAIL div_overflow: got %h expected %h", r, M_EN ? 32'h8000_0000 : 32'd0); end
        do_div(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, r, c, b, rw);
        nvec++;
        if (r !== 32'd0) begin nerr++; $display("FAIL rem_overflow: got %h expected 00000000", r); end
        do_div(5'd21, 32'd100, 32'd7, r, c, b, rw);
        nvec++;
        if (r !== (M_EN ? 32'd14 : 32'd0)) begin nerr++; $display("FAIL divu_plain: got %h expected %h", r, M_EN ? 32'd14 : 32'd0); end
    endtask

    task automatic test_reset_mid_div();
        clear();
        i_reg_write_e = 1'b1; i_alu_ctrl_e = 5'd20; i_rd1_e = 32'hFFFF_FFF9; i_rd2_e = 32'd2; i_rd_e = 5'd7;
        for (int i = 0; i < 10; i++) step();
        clear();
        rstn = 1'b0;
        step();
        nvec++;
        if ({o_reg_write_m, o_result_src_m, o_mem_write_m, o_alu_result_m, o_write_data_m, o_rd_m,
             o_pc_plus_4m, o_ext_imm_m, o_mem_funct3, o_ctrl_mem_byte_sel_m, o_stall_e} !== '0) begin
            nerr++; $display("FAIL reset_mid_div: stall=%b rw=%b rd=%0d alu=%h, all-zero required", o_stall_e, o_reg_write_m, o_rd_m, o_alu_result_m);
        end
        rstn = 1'b1;
        i_reg_write_e = 1'b1; i_alu_src_e = 1'b1; i_rd1_e = 32'd5; i_ext_imm_e = 32'd7; i_rd_e = 5'd4;
        step();
        nvec++;
        if ({o_stall_e, o_reg_write_m, o_rd_m, o_alu_result_m} !== {1'b0, 1'b1, 5'd4, 32'd12}) begin
            nerr++; $display("FAIL add_after_reset: stall=%b rw=%b rd=%0d alu=%h expected 0/1/4/0000000c", o_stall_e, o_reg_write_m, o_rd_m, o_alu_result_m);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_forward();
        test_alu_ops();
        test_passthrough();
        test_branch();
        test_div();
        test_back_to_back();
        test_reset_mid_div();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/riscv_execute.md
Name: riscv_execute

Overview:
- Execute stage of the pipelined RV32 core. Sits between the ID/EX register and riscv_memory.
- Applies operand forwarding, computes ALU and branch results, and owns an iterative divider.
- Drives the EX/MEM register, whose outputs connect one-to-one to the *_m inputs of the memory stage.
- Raises a stall to the hazard unit while a divide is in flight.

Parameters:
- XLEN, 32, datapath width; equals `XLEN.
- DIV_CNT_W, 6, divider iteration counter width; must satisfy 2**DIV_CNT_W > XLEN.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  synchronous active-low reset.
- i_reg_write_e  in  1  register-file write enable from ID/EX.
- i_result_src_e  in  2  writeback result select from ID/EX.
- i_mem_write_e  in  1  data-memory write enable from ID/EX.
- i_branch_e  in  1  instruction is a conditional branch.
- i_jump_e  in  1  instruction is jal/jalr.
- i_jalr_e  in  1  target is rs1+imm, LSB cleared.
- i_alu_src_e  in  1  ALU B select: 0=rs2, 1=imm.
- i_alu_ctrl_e  in  5  ALU operation; encoding in Behaviour.
- i_funct3_e  in  3  funct3; branch condition, passed to memory stage.
- i_ctrl_mem_byte_sel_e  in  4  byte lane select, passed through.
- i_rd1_e, i_rd2_e  in  XLEN  register-file read data.
- i_pc_e, i_pc_plus_4e, i_ext_imm_e  in  XLEN  PC, PC+4, immediate.
- i_rd_e  in  5  destination register.
- i_fwd_a_e, i_fwd_b_e  in  2  forwarding select: 00=regfile, 01=i_result_w, 10=o_alu_result_m, 11=regfile.
- i_result_w  in  XLEN  writeback result.
- o_pc_src_e  out  1  redirect taken (combinational).
- o_pc_target_e  out  XLEN  redirect target (combinational).
- o_stall_e  out  1  hold IF/ID/EX; divider busy.
- o_reg_write_m, o_result_src_m[2], o_mem_write_m, o_alu_result_m[XLEN], o_write_data_m[XLEN], o_rd_m[5], o_pc_plus_4m[XLEN], o_ext_imm_m[XLEN], o_mem_funct3[3], o_ctrl_mem_byte_sel_m[4]  out  EX/MEM register outputs.

Behaviour:
- Operands:
  - srcA = fwd(i_rd1_e, i_fwd_a_e).
  - writedata = fwd(i_rd2_e, i_fwd_b_e).
  - srcB = i_alu_src_e ? i_ext_imm_e : writedata.
- ALU encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASSB.
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - Unlisted codes give 0.
  - Shifts use srcB[4:0].
  - MUL* is single-cycle combinational, 64-bit product; MUL returns the low half, MULH* the high half.
- Branch:
  - Condition by funct3: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu; other codes not taken.
  - o_pc_src_e = i_jump_e | (i_branch_e & cond).
  - o_pc_target_e = i_jalr_e ? ((srcA + imm) & ~1) : (i_pc_e + imm).
  - o_pc_src_e is forced to 0 while o_stall_e = 1.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY when i_alu_ctrl_e is 20..23. Latch srcA, srcB and signedness; counter = XLEN; o_stall_e = 1.
  - BUSY: one restoring step per cycle on magnitudes; counter decrements; o_stall_e = 1. BUSY -> DONE when counter reaches 1 and that step executes.
  - DONE: o_stall_e = 0; sign-corrected quotient or remainder drives the ALU result; EX/MEM captures it; next state IDLE.
  - Issue-to-capture is XLEN+2 cycles; stall is high for XLEN+1 cycles.
  - The latched operands are used throughout, so forwarding changes during the stall are ignored.
- Divide corner cases:
  - Divisor 0: quotient = all ones, remainder = dividend.
  - Signed 0x80000000 / -1: quotient = 0x80000000, remainder = 0.
  - REM takes the sign of the dividend.
- EX/MEM register:
  - Updates every cycle.
  - While o_stall_e = 1 it loads a bubble: reg_write = 0, mem_write = 0; other fields hold.
  - Otherwise it loads the ALU result, writedata, and pass-through fields.
- Reset (i_rstn = 0 at a clock edge):
  - All EX/MEM outputs go to 0 and the FSM goes to IDLE.
  - Reset mid-divide aborts the divide; o_stall_e is 0 the cycle after.
- Back-to-back divides: the second divide issues one cycle after DONE, because upstream advances on DONE.

Optional Feature:
- Macro: RV32M_EN.
- Defined: codes 16..23 behave as specified above.
- Undefined: codes 16..23 give ALU result 0. The divider FSM is not built and o_stall_e is tied to 0.

Test Plan:
- ADD, rd1 = 5, imm = 7, alu_src = 1 -> next cycle o_alu_result_m = 12 and o_reg_write_m = 1.
- SUB with i_fwd_a_e = 10, previous o_alu_result_m = 0x20, rd2 = 3 -> o_alu_result_m = 0x1D.
- BEQ with rs1 = rs2 = 9, pc = 0x100, imm = 0x40 -> o_pc_src_e = 1 and o_pc_target_e = 0x140 in the same cycle. JALR with srcA = 0x203, imm = 0 -> target = 0x202.
- DIV -7/2 -> o_stall_e high for 33 cycles, then o_alu_result_m = 0xFFFFFFFD. REM of the same operands -> 0xFFFFFFFF. During the stall o_reg_write_m = 0.
- DIVU x/0 with x = 0x1234 -> quotient = 0xFFFFFFFF; REMU -> 0x1234. Signed 0x80000000 / -1 -> 0x80000000.
- Assert i_rstn = 0 at cycle 10 of a DIV -> the next cycle all outputs are 0 and o_stall_e = 0. A subsequent ADD executes normally.
